// File: rtl/wb_master_core.sv
// Single-outstanding Wishbone B4 pipelined master: one command in, one response pulse out.
// Optional bus timeout is built when WB_MASTER_TIMEOUT_EN is defined.
module wb_master_core #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // command port
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
    // response port
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    // wishbone master side
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic [SEL_WIDTH-1:0]  sel_o,
    output logic                  we_o,
    output logic                  stb_o,
    output logic                  cyc_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i,
    input  logic                  err_i,
    input  logic                  stall_i,
    // FSM state for debug/checkers: 0 IDLE, 1 REQ, 2 WAIT, 3 RESP
    output logic [1:0]            state_dbg_o
);

    // Command handshake: a command transfers on a rising edge where cmd_valid_i and
    // cmd_ready_o are both high; rsp_valid_o is a one-cycle pulse with no backpressure.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t state;
    logic   term_hit;
    logic   tmo_hit;

    assign cmd_ready_o = (state == S_IDLE) && !rst_i;
    assign state_dbg_o = state;

    // A strobe still stalled cannot be terminated; ack/err only count once it is accepted.
    always_comb begin
        term_hit = 1'b0;
        case (state)
            S_REQ:   term_hit = !stall_i && (ack_i || err_i);
            S_WAIT:  term_hit = ack_i || err_i;
            default: term_hit = 1'b0;
        endcase
    end

`ifdef WB_MASTER_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
        end else if (state == S_IDLE && cmd_valid_i) begin
            tmo_cnt <= '0;
        end else if (state == S_REQ || state == S_WAIT) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Counter holds (cycles of cyc_o so far - 1), so this fires at the end of the last allowed cycle.
    assign tmo_hit = (state == S_REQ || state == S_WAIT) &&
                     (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit       = 1'b0;
    assign rsp_timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            adr_o       <= '0;
            dat_o       <= '0;
            sel_o       <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
            rsp_timeout_o <= 1'b0;
`endif
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        adr_o <= cmd_adr_i;
                        dat_o <= cmd_dat_i;
                        sel_o <= cmd_sel_i;
                        we_o  <= cmd_we_i;
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        state <= S_REQ;
                    end
                end
                S_REQ, S_WAIT: begin
                    // A real termination on the final cycle beats the timeout.
                    if (term_hit) begin
                        state       <= S_RESP;
                        cyc_o       <= 1'b0;
                        stb_o       <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= err_i;
                        rsp_dat_o   <= (err_i || we_o) ? '0 : dat_i;
`ifdef WB_MASTER_TIMEOUT_EN
                        rsp_timeout_o <= 1'b0;
`endif
                    end else if (tmo_hit) begin
                        state       <= S_RESP;
                        cyc_o       <= 1'b0;
                        stb_o       <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_dat_o   <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
                        rsp_timeout_o <= 1'b1;
`endif
                    end else if (state == S_REQ && !stall_i) begin
                        stb_o <= 1'b0;
                        state <= S_WAIT;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_core.sv
// Self-checking bench for wb_master_core: directed transfers, reset in WAIT, back-to-back and random commands.
// Timeout scenarios are exercised when WB_MASTER_TIMEOUT_EN is defined.
module tb_wb_master_core;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;
    localparam int W  = DW + 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_we_i = 1'b0;
    logic [AW-1:0] cmd_adr_i = '0;
    logic [DW-1:0] cmd_dat_i = '0;
    logic [SW-1:0] cmd_sel_i = '0;
    logic          rsp_valid_o;
    logic [DW-1:0] rsp_dat_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic [SW-1:0] sel_o;
    logic          we_o;
    logic          stb_o;
    logic          cyc_o;
    logic [DW-1:0] dat_i = '0;
    logic          ack_i = 1'b0;
    logic          err_i = 1'b0;
    logic          stall_i = 1'b0;
    logic [1:0]    state_dbg_o;

    int total = 0;
    int bad = 0;
    int cmd_cnt = 0;
    int rsp_cnt = 0;
    logic [W-1:0] exp_q[$];

    wb_master_core #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o), .stb_o(stb_o), .cyc_o(cyc_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .stall_i(stall_i),
        .state_dbg_o(state_dbg_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // scoreboard: every response pulse pops one expected {err, timeout, data}
    always @(negedge clk_i) begin
        if (rsp_valid_o) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("rsp", {rsp_err_o, rsp_timeout_o, rsp_dat_o}, e);
            end
            check("rsp_cyc_low", cyc_o, 0);
        end
    end

    // kind: 0 ack, 1 err, 2 err+ack, 3 never terminate; waits < 0 terminates in the accept cycle
    task automatic do_cmd(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input logic [SW-1:0] sel, input int stalls, input int waits,
                          input int kind, input logic [DW-1:0] rdata, input bit keep_valid);
        int term, exp_cyc, exp_stb, cyc_n, stb_n;
        bit bus_ok, got_rdy;
        logic [W-1:0] e;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        cmd_sel_i   = sel;
        cmd_valid_i = 1'b1;
        got_rdy = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (cmd_ready_o) begin
                got_rdy = 1'b1;
                break;
            end
            tick();
        end
        if (!got_rdy) begin
            check("cmd_ready_wait", 0, 1);
            cmd_valid_i = 1'b0;
            return;
        end
        tick();
        cmd_cnt++;
        if (!keep_valid) cmd_valid_i = 1'b0;

        if (kind == 3) begin
            e = {2'b11, {DW{1'b0}}};
            term = -1;
            exp_cyc = TO;
            exp_stb = (stalls + 1 < TO) ? stalls + 1 : TO;
        end else begin
            if (kind == 0) e = {2'b00, (we ? {DW{1'b0}} : rdata)};
            else           e = {2'b10, {DW{1'b0}}};
            term = (waits < 0) ? stalls + 1 : stalls + 2 + waits;
            exp_cyc = term;
            exp_stb = stalls + 1;
        end
        exp_q.push_back(e);

        cyc_n = 0;
        stb_n = 0;
        bus_ok = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            stall_i = (c <= stalls);
            ack_i   = (c == term) && (kind == 0 || kind == 2);
            err_i   = (c == term) && (kind == 1 || kind == 2);
            dat_i   = (c == term) ? rdata : $urandom;
            @(negedge clk_i);
            if (!cyc_o) break;
            cyc_n++;
            if (stb_o) stb_n++;
            if (adr_o !== adr || dat_o !== dat || sel_o !== sel || we_o !== we) bus_ok = 1'b0;
            tick();
        end
        stall_i = 1'b0;
        ack_i   = 1'b0;
        err_i   = 1'b0;
        check("cyc_len", cyc_n, exp_cyc);
        check("stb_len", stb_n, exp_stb);
        check("bus_hold", bus_ok, 1);
        tick();
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_cyc", cyc_o, 0);
        check("rst_stb", stb_o, 0);
        check("rst_ready_low", cmd_ready_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_adr", adr_o, 0);
        check("rst_state", state_dbg_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_rst", cmd_ready_o, 1);
        tick();

        // zero-wait write, ack one cycle after the strobe
        do_cmd(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'hA5A5A5A5, 1'b0);
        // read with three stall cycles
        do_cmd(1'b0, 16'h0020, 32'h0, 4'hF, 3, 0, 0, 32'h12345678, 1'b0);
        // err and ack together: error wins
        do_cmd(1'b0, 16'h0030, 32'h0, 4'h3, 0, 1, 2, 32'hCAFEF00D, 1'b0);
        // error in the same cycle the strobe is accepted
        do_cmd(1'b0, 16'h0034, 32'h0, 4'h1, 1, -1, 1, 32'h11112222, 1'b0);
        // ack in the accept cycle
        do_cmd(1'b0, 16'h0038, 32'h0, 4'hC, 0, -1, 0, 32'h0BADBEEF, 1'b0);

`ifdef WB_MASTER_TIMEOUT_EN
        do_cmd(1'b0, 16'h0040, 32'h0, 4'hF, 0, 0, 3, 32'h0, 1'b0);
        do_cmd(1'b0, 16'h0044, 32'h0, 4'hF, 0, TO - 2, 0, 32'h55667788, 1'b0);
        do_cmd(1'b1, 16'h0048, 32'h13579BDF, 4'hF, 20, 0, 3, 32'h0, 1'b0);
`else
        // no timeout: a long wait still completes normally
        do_cmd(1'b0, 16'h0040, 32'h0, 4'hF, 2, 25, 0, 32'h55667788, 1'b0);
`endif

        // reset while in WAIT: bus drops at that edge, no response
        cmd_we_i = 1'b1; cmd_adr_i = 16'h00F0; cmd_dat_i = 32'h01020304; cmd_sel_i = 4'hF;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        @(negedge clk_i);
        check("wait_cyc", cyc_o, 1);
        check("wait_stb", stb_o, 0);
        #1;
        rst_i = 1'b1;
        tick();
        check("rstw_cyc", cyc_o, 0);
        check("rstw_stb", stb_o, 0);
        check("rstw_we", we_o, 0);
        check("rstw_adr", adr_o, 0);
        check("rstw_ready_low", cmd_ready_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rstw_ready", cmd_ready_o, 1);
        tick();
        repeat (3) tick();

        // back-to-back with cmd_valid held high
        for (int i = 0; i < 4; i++) begin
            do_cmd(i[0], 16'(16'h0100 + i * 4), 32'(32'hB0B00000 + i), 4'hF, 0, 0, 0,
                   32'(32'h70000000 + i), 1'b1);
        end
        cmd_valid_i = 1'b0;

        // stray ack/err in IDLE
        ack_i = 1'b1;
        tick();
        err_i = 1'b1;
        ack_i = 1'b0;
        tick();
        err_i = 1'b0;
        @(negedge clk_i);
        check("stray_cyc", cyc_o, 0);
        check("stray_state", state_dbg_o, 0);
        tick();

        // random commands
        for (int i = 0; i < 10; i++) begin
            do_cmd(1'($urandom_range(0, 1)), 16'($urandom), $urandom, 4'($urandom_range(1, 15)),
                   $urandom_range(0, 3), int'($urandom_range(0, 4)) - 1, $urandom_range(0, 2),
                   $urandom, 1'($urandom_range(0, 1)));
        end
        cmd_valid_i = 1'b0;
        repeat (4) tick();

        check("queue_empty", exp_q.size(), 0);
        check("rsp_count", rsp_cnt, cmd_cnt);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
